core_ifetch: RTL and testbench

Instruction fetch stage of the W0RM core. It generates sequential 16-bit instruction fetch addresses and issues them to the instruction memory port. It buffers in-order responses in a small FIFO and presents them to decode. It consumes the branch unit's redirect (next_pc / next_pc_valid, which is also flush_pipeline) to restart fetch at the target and discard stale in-flight responses.

---
 rtl/core_ifetch.sv | 160 ++++++++++++++++
 tb/tb_core_ifetch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_ifetch.sv
// core_ifetch: instruction fetch stage of the W0RM core.
//
// Issues sequential 16-bit instruction fetch requests to the instruction memory,
// buffers the in-order responses in a small FIFO and presents them to decode.
// A branch redirect restarts fetch at the target, flushes the buffer and
// arranges for responses that are still in flight to be discarded.
//
// Ports:
//   clk                  core clock, all state updates on the rising edge
//   reset                asynchronous, active-high reset
//   inst_mem_valid       fetch request valid
//   inst_mem_addr        fetch request byte address (bit 0 always 0)
//   inst_mem_ready       memory accepts the request when valid && ready
//   inst_mem_data_valid  response valid (in order, one per accepted request)
//   inst_mem_data        response instruction word
//   branch_pc_valid      redirect request (also acts as pipeline flush)
//   branch_pc            redirect target (bit 0 ignored)
//   inst_valid           instruction available to decode
//   inst_data            instruction word at the buffer head
//   inst_addr            byte address of inst_data
//   decode_ready         decode pops the head when inst_valid && decode_ready
module core_ifetch #(
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter int unsigned             INST_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0,
    parameter int unsigned             FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  inst_mem_valid,
    output logic [ADDR_WIDTH-1:0] inst_mem_addr,
    input  logic                  inst_mem_ready,
    input  logic                  inst_mem_data_valid,
    input  logic [INST_WIDTH-1:0] inst_mem_data,
    input  logic                  branch_pc_valid,
    input  logic [ADDR_WIDTH-1:0] branch_pc,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic                  decode_ready
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);  // pointer width
    localparam int unsigned CW = PW + 1;              // counter width, holds 0..FIFO_DEPTH
    localparam int unsigned SW = CW + 1;              // width of count+outstanding sum
    localparam logic [SW-1:0]         DEPTH_S = SW'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(2);

    // Architectural state
    logic [ADDR_WIDTH-1:0] pc;           // next request address
    logic [ADDR_WIDTH-1:0] resp_pc;      // address of next kept response
    logic [CW-1:0]         outstanding;  // accepted, unanswered requests
    logic [CW-1:0]         drop;         // stale responses still to discard
    logic [CW-1:0]         fifo_count;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    logic [INST_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];

    // Derived control
    logic                  credit_ok;
    logic                  req_fire;
    logic                  resp_discard;
    logic                  push;
    logic                  pop;
    logic                  fifo_empty;
    logic [ADDR_WIDTH-1:0] target_pc;

    logic branch_pc_lsb_unused;
    assign branch_pc_lsb_unused = branch_pc[0];

    // Only ask for what the buffer is guaranteed to absorb: entries already
    // held plus responses still owed must leave room for one more.
    assign credit_ok  = ({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_S;
    assign fifo_empty = (fifo_count == '0);
    assign target_pc  = {branch_pc[ADDR_WIDTH-1:1], 1'b0};

    always_comb begin
        inst_mem_valid = ~reset & ~branch_pc_valid & credit_ok;
        inst_mem_addr  = pc;
        inst_valid     = ~reset & ~branch_pc_valid & ~fifo_empty;
        inst_data      = '0;
        inst_addr      = '0;
        if (!fifo_empty) begin
            inst_data = fifo_data[rd_ptr];
            inst_addr = fifo_addr[rd_ptr];
        end
    end

    always_comb begin
        req_fire     = inst_mem_valid & inst_mem_ready;
        resp_discard = inst_mem_data_valid & (drop != '0);
        // A response arriving in a redirect cycle belongs to the old stream.
        push         = inst_mem_data_valid & (drop == '0) & ~branch_pc_valid;
        pop          = inst_valid & decode_ready;
    end

    // Fetch address, response address and the in-flight bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            // req_fire is already blocked during a redirect, so the
            // outstanding update needs no special case.
            outstanding <= outstanding + CW'(req_fire) - CW'(inst_mem_data_valid);

            if (branch_pc_valid) begin
                pc      <= target_pc;
                resp_pc <= target_pc;
                // Everything still owed by memory is stale, except a response
                // consumed (and thrown away) this very cycle.
                drop    <= outstanding - CW'(inst_mem_data_valid);
            end else begin
                if (req_fire) begin
                    pc <= pc + PC_STEP;
                end
                if (push) begin
                    resp_pc <= resp_pc + PC_STEP;
                end
                if (resp_discard) begin
                    drop <= drop - CW'(1);
                end
            end
        end
    end

    // Buffer pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (branch_pc_valid) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    // Buffer storage; contents are only observed through the count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= inst_mem_data;
            fifo_addr[wr_ptr] <= resp_pc;
        end
    end

endmodule

// File: tb/tb_core_ifetch.sv
module tb_core_ifetch;

    localparam int unsigned AW = 32;
    localparam int unsigned IW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          inst_mem_valid;
    logic [AW-1:0] inst_mem_addr;
    logic          inst_mem_ready;
    logic          inst_mem_data_valid;
    logic [IW-1:0] inst_mem_data;
    logic          branch_pc_valid;
    logic [AW-1:0] branch_pc;
    logic          inst_valid;
    logic [IW-1:0] inst_data;
    logic [AW-1:0] inst_addr;
    logic          decode_ready;

    core_ifetch #(
        .ADDR_WIDTH (AW),
        .INST_WIDTH (IW),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .inst_mem_valid      (inst_mem_valid),
        .inst_mem_addr       (inst_mem_addr),
        .inst_mem_ready      (inst_mem_ready),
        .inst_mem_data_valid (inst_mem_data_valid),
        .inst_mem_data       (inst_mem_data),
        .branch_pc_valid     (branch_pc_valid),
        .branch_pc           (branch_pc),
        .inst_valid          (inst_valid),
        .inst_data           (inst_data),
        .inst_addr           (inst_addr),
        .decode_ready        (decode_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [81:0] act, input logic [81:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycle vector: inputs applied on the falling edge, outputs checked 1ns later.
    typedef struct {
        logic          rst;
        logic          rdy;
        logic          dv;
        logic [IW-1:0] data;
        logic          bv;
        logic [AW-1:0] bpc;
        logic          dr;
        logic          mv;
        logic [AW-1:0] maddr;
        logic          iv;
        logic [IW-1:0] idata;
        logic [AW-1:0] iaddr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(logic rst, logic rdy, logic dv, logic [IW-1:0] data,
                                 logic bv, logic [AW-1:0] bpc, logic dr,
                                 logic mv, logic [AW-1:0] maddr, logic iv,
                                 logic [IW-1:0] idata, logic [AW-1:0] iaddr);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.dv = dv; v.data = data; v.bv = bv; v.bpc = bpc;
        v.dr = dr; v.mv = mv; v.maddr = maddr; v.iv = iv; v.idata = idata; v.iaddr = iaddr;
        return v;
    endfunction

    // Behavioural memory used by the multi-cycle sequences.
    logic [AW-1:0] mq_addr[$];
    int            mq_due[$];
    logic [AW-1:0] acc_q[$];
    logic [AW-1:0] pop_a[$];
    logic [IW-1:0] pop_d[$];
    int            cyc;
    int            lat;

    function automatic logic [IW-1:0] memword(logic [AW-1:0] a);
        return a[15:0] ^ 16'h3C00;
    endfunction

    task automatic seq_reset();
        @(negedge clk);
        reset = 1'b1;
        branch_pc_valid = 1'b0;
        inst_mem_data_valid = 1'b0;
        inst_mem_data = '0;
        inst_mem_ready = 1'b1;
        decode_ready = 1'b1;
        mq_addr.delete(); mq_due.delete();
        acc_q.delete(); pop_a.delete(); pop_d.delete();
        cyc = 0;
    endtask

    task automatic mstep(input logic bv, input logic [AW-1:0] bpc);
        @(negedge clk);
        reset = 1'b0;
        branch_pc_valid = bv;
        branch_pc = bpc;
        inst_mem_data_valid = 1'b0;
        inst_mem_data = '0;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            inst_mem_data_valid = 1'b1;
            inst_mem_data = memword(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        #1;
        if (inst_mem_valid && inst_mem_ready) begin
            acc_q.push_back(inst_mem_addr);
            mq_addr.push_back(inst_mem_addr);
            mq_due.push_back(cyc + lat);
        end
        if (inst_valid && decode_ready) begin
            pop_a.push_back(inst_addr);
            pop_d.push_back(inst_data);
        end
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        inst_mem_ready = 1'b0;
        inst_mem_data_valid = 1'b0;
        inst_mem_data = '0;
        branch_pc_valid = 1'b0;
        branch_pc = '0;
        decode_ready = 1'b0;

        //            rst rdy dv data      bv bpc    dr | mv maddr  iv idata     iaddr
        vecs.push_back(mkv(1, 0, 0, 16'h0000, 0, 32'h0,   0,  0, 32'h0,   0, 16'h0000, 32'h0));
        vecs.push_back(mkv(0, 1, 0, 16'h0000, 0, 32'h0,   1,  1, 32'h0,   0, 16'h0000, 32'h0));
        vecs.push_back(mkv(0, 1, 1, 16'h1000, 0, 32'h0,   1,  1, 32'h2,   0, 16'h0000, 32'h0));
        vecs.push_back(mkv(0, 1, 1, 16'h1002, 0, 32'h0,   1,  1, 32'h4,   1, 16'h1000, 32'h0));
        vecs.push_back(mkv(0, 1, 1, 16'h1004, 0, 32'h0,   1,  1, 32'h6,   1, 16'h1002, 32'h2));
        vecs.push_back(mkv(0, 1, 1, 16'h1006, 0, 32'h0,   0,  1, 32'h8,   1, 16'h1004, 32'h4));
        vecs.push_back(mkv(0, 1, 1, 16'h1008, 0, 32'h0,   0,  1, 32'hA,   1, 16'h1004, 32'h4));
        vecs.push_back(mkv(0, 1, 1, 16'h100A, 0, 32'h0,   0,  0, 32'hC,   1, 16'h1004, 32'h4));
        vecs.push_back(mkv(0, 1, 0, 16'h0000, 0, 32'h0,   0,  0, 32'hC,   1, 16'h1004, 32'h4));
        vecs.push_back(mkv(0, 1, 0, 16'h0000, 0, 32'h0,   1,  0, 32'hC,   1, 16'h1004, 32'h4));
        vecs.push_back(mkv(0, 1, 0, 16'h0000, 0, 32'h0,   1,  1, 32'hC,   1, 16'h1006, 32'h6));
        vecs.push_back(mkv(0, 1, 1, 16'h100C, 0, 32'h0,   1,  1, 32'hE,   1, 16'h1008, 32'h8));
        // redirect together with a response and a decode pop
        vecs.push_back(mkv(0, 1, 1, 16'h100E, 1, 32'h201, 1,  0, 32'h10,  0, 16'h100A, 32'hA));
        vecs.push_back(mkv(0, 1, 0, 16'h0000, 0, 32'h0,   1,  1, 32'h200, 0, 16'h0000, 32'h0));
        vecs.push_back(mkv(0, 1, 1, 16'h2000, 0, 32'h0,   1,  1, 32'h202, 0, 16'h0000, 32'h0));
        vecs.push_back(mkv(0, 1, 0, 16'h0000, 0, 32'h0,   1,  1, 32'h204, 1, 16'h2000, 32'h200));
        // redirect with two requests in flight: next two responses are stale
        vecs.push_back(mkv(0, 1, 0, 16'h0000, 1, 32'h300, 1,  0, 32'h206, 0, 16'h0000, 32'h0));
        vecs.push_back(mkv(0, 1, 1, 16'hDEAD, 0, 32'h0,   1,  1, 32'h300, 0, 16'h0000, 32'h0));
        vecs.push_back(mkv(0, 1, 1, 16'hBEEF, 0, 32'h0,   1,  1, 32'h302, 0, 16'h0000, 32'h0));
        vecs.push_back(mkv(0, 1, 1, 16'h3000, 0, 32'h0,   1,  1, 32'h304, 0, 16'h0000, 32'h0));
        vecs.push_back(mkv(0, 1, 1, 16'h3002, 0, 32'h0,   1,  1, 32'h306, 1, 16'h3000, 32'h300));
        vecs.push_back(mkv(0, 1, 1, 16'h3004, 0, 32'h0,   0,  1, 32'h308, 1, 16'h3002, 32'h302));
        // asynchronous reset with two buffered entries and two in flight
        vecs.push_back(mkv(1, 1, 0, 16'h0000, 0, 32'h0,   1,  0, 32'h0,   0, 16'h0000, 32'h0));
        vecs.push_back(mkv(0, 1, 0, 16'h0000, 0, 32'h0,   1,  1, 32'h0,   0, 16'h0000, 32'h0));
        vecs.push_back(mkv(0, 1, 1, 16'h1000, 0, 32'h0,   1,  1, 32'h2,   0, 16'h0000, 32'h0));
        vecs.push_back(mkv(0, 1, 0, 16'h0000, 0, 32'h0,   1,  1, 32'h4,   1, 16'h1000, 32'h0));

        foreach (vecs[i]) begin
            @(negedge clk);
            reset               = vecs[i].rst;
            inst_mem_ready      = vecs[i].rdy;
            inst_mem_data_valid = vecs[i].dv;
            inst_mem_data       = vecs[i].data;
            branch_pc_valid     = vecs[i].bv;
            branch_pc           = vecs[i].bpc;
            decode_ready        = vecs[i].dr;
            #1;
            chk($sformatf("vec%0d", i),
                {inst_mem_valid, inst_mem_addr, inst_valid, inst_data, inst_addr},
                {vecs[i].mv, vecs[i].maddr, vecs[i].iv, vecs[i].idata, vecs[i].iaddr});
        end

        // Three requests in flight (10,12,14), then redirect to 0x101.
        // The memory answers four cycles after acceptance so all three are
        // still pending when the redirect lands.
        lat = 4;
        seq_reset();
        mstep(1'b1, 32'h10);
        mstep(1'b0, '0);
        mstep(1'b0, '0);
        mstep(1'b0, '0);
        mstep(1'b1, 32'h101);
        for (int k = 0; k < 14; k++) mstep(1'b0, '0);
        chk("lat_acc_cnt_ge4", 82'(acc_q.size() >= 4), 82'(1));
        if (acc_q.size() >= 4) begin
            chk("lat_acc0", 82'(acc_q[0]), 82'(32'h10));
            chk("lat_acc1", 82'(acc_q[1]), 82'(32'h12));
            chk("lat_acc2", 82'(acc_q[2]), 82'(32'h14));
            chk("lat_redirect_addr", 82'(acc_q[3]), 82'(32'h100));
        end
        chk("lat_pop_cnt_ge3", 82'(pop_a.size() >= 3), 82'(1));
        if (pop_a.size() >= 3) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("lat_pop%0d", k), {pop_d[k], pop_a[k]},
                    {memword(32'h100 + 32'(2 * k)), 32'h100 + 32'(2 * k)});
            end
        end

        // Sequential fetch across the top of the address space.
        lat = 1;
        seq_reset();
        mstep(1'b1, 32'hFFFF_FFFC);
        for (int k = 0; k < 8; k++) mstep(1'b0, '0);
        chk("wrap_acc_cnt_ge4", 82'(acc_q.size() >= 4), 82'(1));
        if (acc_q.size() >= 4) begin
            chk("wrap_acc0", 82'(acc_q[0]), 82'(32'hFFFF_FFFC));
            chk("wrap_acc1", 82'(acc_q[1]), 82'(32'hFFFF_FFFE));
            chk("wrap_acc2", 82'(acc_q[2]), 82'(32'h0000_0000));
            chk("wrap_acc3", 82'(acc_q[3]), 82'(32'h0000_0002));
        end
        chk("wrap_pop_cnt_ge3", 82'(pop_a.size() >= 3), 82'(1));
        if (pop_a.size() >= 3) begin
            chk("wrap_pop0", {pop_d[0], pop_a[0]}, {memword(32'hFFFF_FFFC), 32'hFFFF_FFFC});
            chk("wrap_pop1", {pop_d[1], pop_a[1]}, {memword(32'hFFFF_FFFE), 32'hFFFF_FFFE});
            chk("wrap_pop2", {pop_d[2], pop_a[2]}, {memword(32'h0), 32'h0});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
